mem_port_arbiter: RTL and testbench

- Shares the single-port unified memory between the instruction-fetch requester (fetch stage of the pipeline controller) and the load/store requester (LDR/STR execute path).
- Sequences each access: arbitration, issue, latency wait and response, using a req/gnt/rvalid handshake per requester.
- Load/store has priority. A starvation guard forces a fetch grant after a bounded run of load/store grants.
- Provides a flush input so the pipeline controller can discard an in-flight fetch on a branch.

---
 rtl/cpu_mem_pkg.sv | 24 ++
 rtl/mem_arb_priority.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, transaction
// owner and a width helper for the small internal counters.
package cpu_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_CAPTURE,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    OWNER_NONE,
    OWNER_IF,
    OWNER_LS
  } owner_e;

  // Bits needed to hold any value in 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arb_priority.sv
// Winner selection between fetch and load/store, with the starvation counter
// that eventually forces a fetch through a continuous load/store stream.
module mem_arb_priority
  import cpu_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_arb_en,
  input  logic i_if_req,
  input  logic i_ls_req,
  output logic o_grant_if,
  output logic o_grant_ls
);

  localparam int CNT_W = cnt_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_starved;

  assign w_starved  = (r_starve_cnt == LIMIT);
  assign o_grant_if = i_if_req & (~i_ls_req | w_starved);
  assign o_grant_ls = i_ls_req & ~o_grant_if;

  // Only counts load/store wins that actually held back a waiting fetch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve_cnt <= '0;
    end else if (i_arb_en) begin
      if (o_grant_if || !i_if_req) begin
        r_starve_cnt <= '0;
      end else if (o_grant_ls && !w_starved) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// sequencing arbitrate / issue / latency wait / capture / respond per access.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_ls_req,
  input  logic              i_ls_we,
  input  logic [ADDR_W-1:0] i_ls_addr,
  input  logic [DATA_W-1:0] i_ls_wdata,
  output logic              o_ls_gnt,
  output logic              o_ls_rvalid,
  output logic [DATA_W-1:0] o_ls_rdata,
  output logic              o_mem_en,
  output logic              o_mem_write_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("mem_port_arbiter: MEM_LATENCY must be at least 1");
  end

  localparam int LAT_W = cnt_width(MEM_LATENCY);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LATENCY - 1);

  state_e            r_state, w_state_next;
  owner_e            r_owner, w_owner_next;
  logic              r_cur_we, w_cur_we_next;
  logic [LAT_W-1:0]  r_lat_cnt, w_lat_next;
  logic              r_kill, w_kill_next;

  logic              r_if_gnt, w_if_gnt_next;
  logic              r_if_rvalid, w_if_rvalid_next;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_ls_gnt, w_ls_gnt_next;
  logic              r_ls_rvalid, w_ls_rvalid_next;
  logic [DATA_W-1:0] r_ls_rdata;
  logic              r_mem_en, w_mem_en_next;
  logic              r_mem_we, w_mem_we_next;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_next;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_next;

  logic              w_arb_en;
  logic              w_if_req_eff;
  logic              w_grant_if;
  logic              w_grant_ls;
  logic              w_cap_if;
  logic              w_cap_ls;
  logic              w_fetch_inflight;

  // A flush at an arbitration point hides the fetch request for that cycle.
  assign w_arb_en     = (r_state == ST_IDLE) || (r_state == ST_RESP);
  assign w_if_req_eff = i_if_req & ~i_flush;

  mem_arb_priority #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_priority (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_arb_en   (w_arb_en),
    .i_if_req   (w_if_req_eff),
    .i_ls_req   (i_ls_req),
    .o_grant_if (w_grant_if),
    .o_grant_ls (w_grant_ls)
  );

  assign w_fetch_inflight = (r_owner == OWNER_IF) &&
                            ((r_state == ST_ACCESS) || (r_state == ST_WAIT) ||
                             (r_state == ST_CAPTURE));

  always_comb begin
    w_state_next     = r_state;
    w_owner_next     = r_owner;
    w_cur_we_next    = r_cur_we;
    w_lat_next       = r_lat_cnt;
    w_kill_next      = r_kill;
    w_if_gnt_next    = 1'b0;
    w_if_rvalid_next = 1'b0;
    w_ls_gnt_next    = 1'b0;
    w_ls_rvalid_next = 1'b0;
    w_mem_en_next    = 1'b0;
    w_mem_we_next    = 1'b0;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_cap_if         = 1'b0;
    w_cap_ls         = 1'b0;

    case (r_state)
      ST_IDLE, ST_RESP: begin
        w_state_next  = ST_IDLE;
        w_owner_next  = OWNER_NONE;
        w_cur_we_next = 1'b0;
        w_kill_next   = 1'b0;
        if (w_grant_ls) begin
          w_state_next     = ST_ACCESS;
          w_owner_next     = OWNER_LS;
          w_cur_we_next    = i_ls_we;
          w_ls_gnt_next    = 1'b1;
          w_mem_en_next    = 1'b1;
          w_mem_we_next    = i_ls_we;
          w_mem_addr_next  = i_ls_addr;
          w_mem_wdata_next = i_ls_wdata;
        end else if (w_grant_if) begin
          w_state_next    = ST_ACCESS;
          w_owner_next    = OWNER_IF;
          w_if_gnt_next   = 1'b1;
          w_mem_en_next   = 1'b1;
          w_mem_addr_next = i_if_addr;
        end
      end

      ST_ACCESS: begin
        if (MEM_LATENCY > 1) begin
          w_state_next = ST_WAIT;
          w_lat_next   = LAT_W'(1);
        end else begin
          w_state_next = ST_CAPTURE;
        end
      end

      ST_WAIT: begin
        if (r_lat_cnt == LAT_LAST) begin
          w_state_next = ST_CAPTURE;
        end else begin
          w_lat_next = r_lat_cnt + 1'b1;
        end
      end

      // A flush arriving in this very cycle must also suppress the response.
      ST_CAPTURE: begin
        w_state_next     = ST_RESP;
        w_cap_if         = (r_owner == OWNER_IF);
        w_cap_ls         = (r_owner == OWNER_LS) && !r_cur_we;
        w_if_rvalid_next = (r_owner == OWNER_IF) && !r_kill && !i_flush;
        w_ls_rvalid_next = (r_owner == OWNER_LS);
      end

      default: begin
        w_state_next = ST_IDLE;
        w_owner_next = OWNER_NONE;
      end
    endcase

    if (i_flush && w_fetch_inflight) begin
      w_kill_next = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWNER_NONE;
      r_cur_we    <= 1'b0;
      r_lat_cnt   <= '0;
      r_kill      <= 1'b0;
      r_if_gnt    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_gnt    <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_ls_rdata  <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_next;
      r_owner     <= w_owner_next;
      r_cur_we    <= w_cur_we_next;
      r_lat_cnt   <= w_lat_next;
      r_kill      <= w_kill_next;
      r_if_gnt    <= w_if_gnt_next;
      r_if_rvalid <= w_if_rvalid_next;
      r_ls_gnt    <= w_ls_gnt_next;
      r_ls_rvalid <= w_ls_rvalid_next;
      r_mem_en    <= w_mem_en_next;
      r_mem_we    <= w_mem_we_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      if (w_cap_if) begin
        r_if_rdata <= i_mem_rdata;
      end
      if (w_cap_ls) begin
        r_ls_rdata <= i_mem_rdata;
      end
    end
  end

  assign o_if_gnt       = r_if_gnt;
  assign o_if_rvalid    = r_if_rvalid;
  assign o_if_rdata     = r_if_rdata;
  assign o_ls_gnt       = r_ls_gnt;
  assign o_ls_rvalid    = r_ls_rvalid;
  assign o_ls_rdata     = r_ls_rdata;
  assign o_mem_en       = r_mem_en;
  assign o_mem_write_en = r_mem_we;
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_wdata    = r_mem_wdata;
  assign o_busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at latency 1 and one at
// latency 3, each backed by a pipelined memory model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   passes = 0;

  // Latency-1 instance signals
  logic        flush, ifReq, lsReq, lsWe;
  logic [31:0] ifAddr, lsAddr, lsWdata, memRdata;
  logic        ifGnt, ifRvalid, lsGnt, lsRvalid, memEn, memWe, busy;
  logic [31:0] ifRdata, lsRdata, memAddr, memWdata;

  // Latency-3 instance signals
  logic        sFlush, sIfReq, sLsReq, sLsWe;
  logic [31:0] sIfAddr, sLsAddr, sLsWdata, sMemRdata;
  logic        sIfGnt, sIfRvalid, sLsGnt, sLsRvalid, sMemEn, sMemWe, sBusy;
  logic [31:0] sIfRdata, sLsRdata, sMemAddr, sMemWdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_if_req(ifReq), .i_if_addr(ifAddr),
    .o_if_gnt(ifGnt), .o_if_rvalid(ifRvalid), .o_if_rdata(ifRdata),
    .i_ls_req(lsReq), .i_ls_we(lsWe), .i_ls_addr(lsAddr), .i_ls_wdata(lsWdata),
    .o_ls_gnt(lsGnt), .o_ls_rvalid(lsRvalid), .o_ls_rdata(lsRdata),
    .o_mem_en(memEn), .o_mem_write_en(memWe), .o_mem_addr(memAddr),
    .o_mem_wdata(memWdata), .i_mem_rdata(memRdata), .o_busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .STARVE_LIMIT(4)) u_dut_slow (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(sFlush),
    .i_if_req(sIfReq), .i_if_addr(sIfAddr),
    .o_if_gnt(sIfGnt), .o_if_rvalid(sIfRvalid), .o_if_rdata(sIfRdata),
    .i_ls_req(sLsReq), .i_ls_we(sLsWe), .i_ls_addr(sLsAddr), .i_ls_wdata(sLsWdata),
    .o_ls_gnt(sLsGnt), .o_ls_rvalid(sLsRvalid), .o_ls_rdata(sLsRdata),
    .o_mem_en(sMemEn), .o_mem_write_en(sMemWe), .o_mem_addr(sMemAddr),
    .o_mem_wdata(sMemWdata), .i_mem_rdata(sMemRdata), .o_busy(sBusy)
  );

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    if (addr == 32'h0000_0100) return 32'hE3A0_0001;
    return {addr[15:0], ~addr[15:0]};
  endfunction

  // Read data is only valid exactly MEM_LATENCY cycles after the strobe.
  logic        m1Valid = 1'b0;
  logic [31:0] m1Data = '0;
  logic [2:0]  m3Valid = '0;
  logic [31:0] m3Data [3];

  always @(posedge clk) begin
    m1Valid   <= memEn;
    m1Data    <= memWord(memAddr);
    m3Valid   <= {m3Valid[1:0], sMemEn};
    m3Data[0] <= memWord(sMemAddr);
    m3Data[1] <= m3Data[0];
    m3Data[2] <= m3Data[1];
  end

  assign memRdata  = m1Valid ? m1Data : 32'hBAD0_BAD0;
  assign sMemRdata = m3Valid[2] ? m3Data[2] : 32'hBAD0_BAD0;

  aIfHeld: assert property (@(posedge clk) disable iff (!rst_n) $fell(ifReq) |-> ifGnt)
    else $error("[TB] protocol violation: ifReq dropped before ifGnt");
  aLsHeld: assert property (@(posedge clk) disable iff (!rst_n) $fell(lsReq) |-> lsGnt)
    else $error("[TB] protocol violation: lsReq dropped before lsGnt");
  aSIfHeld: assert property (@(posedge clk) disable iff (!rst_n) $fell(sIfReq) |-> sIfGnt)
    else $error("[TB] protocol violation: sIfReq dropped before sIfGnt");
  aSLsHeld: assert property (@(posedge clk) disable iff (!rst_n) $fell(sLsReq) |-> sLsGnt)
    else $error("[TB] protocol violation: sLsReq dropped before sLsGnt");

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if ({ifGnt, ifRvalid, lsGnt, lsRvalid, memEn, memWe, busy, ifRdata, lsRdata, memAddr, memWdata} !== '0)
      $display("[TB] FAIL reset_outputs: got %h want 0", {ifGnt, ifRvalid, lsGnt, lsRvalid, memEn, memWe, busy, ifRdata, lsRdata, memAddr, memWdata}); else passes++;
    checks++; if ({sIfGnt, sIfRvalid, sLsGnt, sLsRvalid, sMemEn, sMemWe, sBusy, sIfRdata, sLsRdata, sMemAddr, sMemWdata} !== '0)
      $display("[TB] FAIL reset_outputs_slow: got %h want 0", {sIfGnt, sIfRvalid, sLsGnt, sLsRvalid, sMemEn, sMemWe, sBusy, sIfRdata, sLsRdata, sMemAddr, sMemWdata}); else passes++;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    checks++; if (busy !== 1'b0) $display("[TB] FAIL idle_after_reset: busy got %b want 0", busy); else passes++;
  endtask

  task automatic test_single_fetch();
    ifAddr = 32'h100; ifReq = 1'b1;
    tick(1);
    checks++; if ({ifGnt, lsGnt, memEn, memWe} !== 4'b1010) $display("[TB] FAIL fetch_access: gnt/lsgnt/en/we got %b want 1010", {ifGnt, lsGnt, memEn, memWe}); else passes++;
    checks++; if (memAddr !== 32'h100) $display("[TB] FAIL fetch_addr: got %h want 00000100", memAddr); else passes++;
    ifReq = 1'b0;
    tick(1);
    checks++; if ({ifGnt, ifRvalid, memEn, busy} !== 4'b0001) $display("[TB] FAIL fetch_capture: gnt/rvalid/en/busy got %b want 0001", {ifGnt, ifRvalid, memEn, busy}); else passes++;
    tick(1);
    checks++; if (ifRvalid !== 1'b1) $display("[TB] FAIL fetch_rvalid: got %b want 1", ifRvalid); else passes++;
    checks++; if (ifRdata !== 32'hE3A0_0001) $display("[TB] FAIL fetch_rdata: got %h want e3a00001", ifRdata); else passes++;
    tick(1);
    checks++; if ({ifRvalid, busy} !== 2'b00) $display("[TB] FAIL fetch_done: rvalid/busy got %b want 00", {ifRvalid, busy}); else passes++;
  endtask

  task automatic test_simultaneous();
    ifAddr = 32'h104; lsAddr = 32'h200; lsWe = 1'b0;
    ifReq = 1'b1; lsReq = 1'b1;
    tick(1);
    checks++; if ({lsGnt, ifGnt} !== 2'b10) $display("[TB] FAIL simul_first: ls/if gnt got %b want 10", {lsGnt, ifGnt}); else passes++;
    checks++; if (memAddr !== 32'h200) $display("[TB] FAIL simul_ls_addr: got %h want 00000200", memAddr); else passes++;
    lsReq = 1'b0;
    tick(2);
    checks++; if ({lsRvalid, ifRvalid} !== 2'b10) $display("[TB] FAIL simul_ls_rvalid: ls/if rvalid got %b want 10", {lsRvalid, ifRvalid}); else passes++;
    checks++; if (lsRdata !== memWord(32'h200)) $display("[TB] FAIL simul_ls_rdata: got %h want %h", lsRdata, memWord(32'h200)); else passes++;
    tick(1);
    checks++; if ({lsGnt, ifGnt} !== 2'b01) $display("[TB] FAIL simul_second: ls/if gnt got %b want 01", {lsGnt, ifGnt}); else passes++;
    checks++; if (memAddr !== 32'h104) $display("[TB] FAIL simul_if_addr: got %h want 00000104", memAddr); else passes++;
    ifReq = 1'b0;
    tick(2);
    checks++; if (ifRvalid !== 1'b1 || ifRdata !== memWord(32'h104)) $display("[TB] FAIL simul_if_resp: rvalid %b rdata %h want 1 %h", ifRvalid, ifRdata, memWord(32'h104)); else passes++;
    tick(1);
  endtask

  task automatic test_starvation();
    logic [5:0] gotIf = 'x;
    logic [5:0] expIf = 6'b010000;
    int n = 0;
    int cyc = 0;
    lsAddr = 32'h300; lsWe = 1'b0; ifAddr = 32'h108;
    lsReq = 1'b1; ifReq = 1'b1;
    while (n < 6 && cyc < 60) begin
      tick(1);
      cyc++;
      if (lsGnt) begin
        gotIf[n] = 1'b0;
        n++;
        if (n == 6) lsReq = 1'b0;
      end else if (ifGnt) begin
        gotIf[n] = 1'b1;
        n++;
        ifReq = 1'b0;
      end
    end
    checks++; if (n != 6) $display("[TB] FAIL starve_grant_count: got %0d grants want 6", n); else passes++;
    for (int i = 0; i < 6; i++) begin
      checks++; if (gotIf[i] !== expIf[i]) $display("[TB] FAIL starve_order_%0d: fetch-won got %b want %b", i, gotIf[i], expIf[i]); else passes++;
    end
    lsReq = 1'b0; ifReq = 1'b0;
    cyc = 0;
    while (busy && cyc < 20) begin tick(1); cyc++; end
    checks++; if (busy !== 1'b0) $display("[TB] FAIL starve_drain: busy got %b want 0", busy); else passes++;
  endtask

  task automatic test_store();
    lsWe = 1'b1; lsAddr = 32'h40; lsWdata = 32'hDEAD_BEEF; lsReq = 1'b1;
    tick(1);
    checks++; if ({lsGnt, memEn, memWe} !== 3'b111) $display("[TB] FAIL store_access: gnt/en/we got %b want 111", {lsGnt, memEn, memWe}); else passes++;
    checks++; if (memWdata !== 32'hDEAD_BEEF || memAddr !== 32'h40) $display("[TB] FAIL store_bus: wdata %h addr %h want deadbeef 00000040", memWdata, memAddr); else passes++;
    lsReq = 1'b0; lsWe = 1'b0;
    tick(1);
    checks++; if ({memEn, memWe} !== 2'b00) $display("[TB] FAIL store_strobe_end: en/we got %b want 00", {memEn, memWe}); else passes++;
    tick(1);
    checks++; if (lsRvalid !== 1'b1) $display("[TB] FAIL store_rvalid: got %b want 1", lsRvalid); else passes++;
    checks++; if (lsRdata !== memWord(32'h300)) $display("[TB] FAIL store_rdata_hold: got %h want %h", lsRdata, memWord(32'h300)); else passes++;
    tick(1);
  endtask

  task automatic test_flush_arbitration();
    ifAddr = 32'h10C; ifReq = 1'b1; flush = 1'b1;
    tick(1);
    checks++; if ({ifGnt, busy} !== 2'b00) $display("[TB] FAIL flush_arb_block: gnt/busy got %b want 00", {ifGnt, busy}); else passes++;
    flush = 1'b0;
    tick(1);
    checks++; if (ifGnt !== 1'b1) $display("[TB] FAIL flush_arb_release: gnt got %b want 1", ifGnt); else passes++;
    ifReq = 1'b0;
    tick(2);
    checks++; if (ifRvalid !== 1'b1 || ifRdata !== memWord(32'h10C)) $display("[TB] FAIL flush_arb_resp: rvalid %b rdata %h want 1 %h", ifRvalid, ifRdata, memWord(32'h10C)); else passes++;
    tick(1);
  endtask

  task automatic test_flush_in_flight();
    logic rvSeen = 1'b0;
    sIfAddr = 32'h180; sIfReq = 1'b1;
    tick(1);
    checks++; if (sIfGnt !== 1'b1 || sMemAddr !== 32'h180) $display("[TB] FAIL kill_gnt: gnt %b addr %h want 1 00000180", sIfGnt, sMemAddr); else passes++;
    sIfReq = 1'b0;
    tick(1);
    sFlush = 1'b1;
    rvSeen |= sIfRvalid;
    tick(1);
    sFlush = 1'b0;
    rvSeen |= sIfRvalid;
    tick(1);
    rvSeen |= sIfRvalid;
    tick(1);
    rvSeen |= sIfRvalid;
    checks++; if (sBusy !== 1'b1) $display("[TB] FAIL kill_resp_busy: got %b want 1", sBusy); else passes++;
    tick(1);
    rvSeen |= sIfRvalid;
    checks++; if (sBusy !== 1'b0) $display("[TB] FAIL kill_busy_drop: got %b want 0", sBusy); else passes++;
    checks++; if (rvSeen !== 1'b0) $display("[TB] FAIL kill_no_rvalid: rvalid seen %b want 0", rvSeen); else passes++;
    sIfAddr = 32'h184; sIfReq = 1'b1;
    tick(1);
    checks++; if (sIfGnt !== 1'b1 || sMemAddr !== 32'h184) $display("[TB] FAIL refetch_gnt: gnt %b addr %h want 1 00000184", sIfGnt, sMemAddr); else passes++;
    sIfReq = 1'b0;
    tick(3);
    checks++; if (sIfRvalid !== 1'b0) $display("[TB] FAIL refetch_early: rvalid got %b want 0", sIfRvalid); else passes++;
    tick(1);
    checks++; if (sIfRvalid !== 1'b1 || sIfRdata !== memWord(32'h184)) $display("[TB] FAIL refetch_resp: rvalid %b rdata %h want 1 %h", sIfRvalid, sIfRdata, memWord(32'h184)); else passes++;
    tick(1);
  endtask

  task automatic test_reset_mid_wait();
    logic activity = 1'b0;
    sIfAddr = 32'h1C0; sIfReq = 1'b1;
    tick(1);
    checks++; if (sIfGnt !== 1'b1) $display("[TB] FAIL rst_pre_gnt: got %b want 1", sIfGnt); else passes++;
    sIfReq = 1'b0;
    tick(1);
    #3 rst_n = 1'b0;
    #1;
    checks++; if ({sIfGnt, sIfRvalid, sLsGnt, sLsRvalid, sMemEn, sMemWe, sBusy, sIfRdata, sLsRdata, sMemAddr, sMemWdata} !== '0)
      $display("[TB] FAIL rst_async_clear: got %h want 0", {sIfGnt, sIfRvalid, sLsGnt, sLsRvalid, sMemEn, sMemWe, sBusy, sIfRdata, sLsRdata, sMemAddr, sMemWdata}); else passes++;
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      activity |= sIfGnt | sIfRvalid | sLsGnt | sLsRvalid | sBusy;
    end
    checks++; if (activity !== 1'b0) $display("[TB] FAIL rst_abandon: activity seen %b want 0", activity); else passes++;
    sLsAddr = 32'h240; sLsWe = 1'b0; sLsReq = 1'b1;
    tick(1);
    checks++; if (sLsGnt !== 1'b1 || sMemAddr !== 32'h240) $display("[TB] FAIL rst_new_gnt: gnt %b addr %h want 1 00000240", sLsGnt, sMemAddr); else passes++;
    sLsReq = 1'b0;
    tick(4);
    checks++; if (sLsRvalid !== 1'b1 || sLsRdata !== memWord(32'h240)) $display("[TB] FAIL rst_new_resp: rvalid %b rdata %h want 1 %h", sLsRvalid, sLsRdata, memWord(32'h240)); else passes++;
    tick(1);
    checks++; if (sBusy !== 1'b0) $display("[TB] FAIL rst_new_idle: busy got %b want 0", sBusy); else passes++;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0; ifReq = 1'b0; lsReq = 1'b0; lsWe = 1'b0;
    ifAddr = '0; lsAddr = '0; lsWdata = '0;
    sFlush = 1'b0; sIfReq = 1'b0; sLsReq = 1'b0; sLsWe = 1'b0;
    sIfAddr = '0; sLsAddr = '0; sLsWdata = '0;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_store();
    test_flush_arbitration();
    test_flush_in_flight();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
